// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB/BR sequencing,
// Moore datapath controls decoded from state and latched opcode, retire counter.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic [2:0]  alu_op_o,
  output logic        branch_o,
  output logic        branch_ne_o,
  output logic        illegal_o,
  output logic [2:0]  state_o,
  output logic [15:0] retired_o
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;
  logic        dp_en;
  logic        run;
  logic        op_lw, op_sw;

  function automatic logic [2:0] alu_code(input logic [5:0] op);
    case (op)
      OP_R:           alu_code = 3'b010;
      OP_ADDI:        alu_code = 3'b011;
      OP_SLTIU:       alu_code = 3'b100;
      OP_LUI:         alu_code = 3'b101;
      OP_ORI:         alu_code = 3'b110;
      OP_BEQ, OP_BNE: alu_code = 3'b001;
      default:        alu_code = 3'b000;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI, OP_LW, OP_SW: uses_imm = 1'b1;
      default:                                         uses_imm = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign op_lw = (op_q == OP_LW);
  assign op_sw = (op_q == OP_SW);
  // FETCH strobes are gated by reset so nothing requests memory while rst_i is high.
  assign run   = enable_i & ~rst_i;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire       = 1'b0;
    dp_en        = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = 3'b000;
    branch_o     = 1'b0;
    branch_ne_o  = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_read_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        op_d = instr_op_i;
        case (instr_op_i)
          OP_R, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI, OP_LW, OP_SW: state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BR;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        dp_en   = 1'b1;
        state_d = (op_lw || op_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dp_en       = 1'b1;
        mem_read_o  = op_lw;
        mem_write_o = op_sw;
        if (mem_ready_i) begin
          state_d = op_lw ? S_WB : S_FETCH;
          retire  = op_sw;
        end
      end
      S_WB: begin
        dp_en       = 1'b1;
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BR: begin
        dp_en       = 1'b1;
        pc_write_o  = 1'b1;
        branch_o    = (op_q == OP_BEQ);
        branch_ne_o = (op_q == OP_BNE);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (dp_en) begin
      alu_op_o     = alu_code(op_q);
      alu_src_o    = uses_imm(op_q);
      reg_dst_o    = (op_q == OP_R);
      mem_to_reg_o = op_lw;
    end
  end

  assign retired_d = retired_q + {15'd0, retire};
  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-cycle comparison of all
// outputs against an instruction-level phase model, plus directed corner cases.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [5:0]  instr_op_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o;
  logic        alu_src_o, reg_dst_o, mem_to_reg_o, branch_o, branch_ne_o, illegal_o;
  logic [2:0]  alu_op_o, state_o;
  logic [15:0] retired_o;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .instr_op_i(instr_op_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_op_o(alu_op_o), .branch_o(branch_o), .branch_ne_o(branch_ne_o),
    .illegal_o(illegal_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] state;
    logic pc_w, ir_w, mrd, mwr, rw, asrc, rdst, m2r;
    logic [2:0] aluop;
    logic br, bne, ill;
  } ctl_t;

  int          checks = 0;
  int          failures = 0;
  int          busy;
  logic [15:0] exp_ret = '0;
  logic [5:0]  ops [9] = '{6'd0, 6'd8, 6'd9, 6'd15, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    return {state_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
            alu_src_o, reg_dst_o, mem_to_reg_o, alu_op_o, branch_o, branch_ne_o, illegal_o};
  endfunction

  // Instruction-class view of the opcode table.
  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd8, 6'd9, 6'd15, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'd0: return 3'd2;
      6'd8: return 3'd3;
      6'd9: return 3'd4;
      6'd15: return 3'd5;
      6'd13: return 3'd6;
      6'd4, 6'd5: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  task automatic step(input string tag, input ctl_t e);
    @(negedge clk_i);
    chk(tag, 32'(sample()), 32'(e));
    chk({tag, "_ret"}, 32'(retired_o), 32'(exp_ret));
    if (state_o != 3'd0 || mem_read_o) busy++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int idle, input int fwait, input int mwait);
    ctl_t e;
    bit lw, sw, brn;
    int lat;
    lw  = (op == 6'd35);
    sw  = (op == 6'd43);
    brn = (op == 6'd4) || (op == 6'd5);
    busy = 0;
    enable_i = 1'b0;
    for (int i = 0; i < idle; i++) begin
      mem_ready_i = 1'($urandom);
      e = '0;
      step("idle", e);
    end
    enable_i = 1'b1;
    mem_ready_i = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      e = '0; e.mrd = 1'b1;
      step("fetch_wait", e);
    end
    mem_ready_i = 1'b1;
    e = '0; e.mrd = 1'b1; e.ir_w = 1'b1; e.pc_w = 1'b1;
    step("fetch", e);
    enable_i = 1'($urandom);
    mem_ready_i = 1'($urandom);
    instr_op_i = op;
    e = '0; e.state = 3'd1; e.ill = !is_legal(op);
    step("decode", e);
    instr_op_i = 6'($urandom);
    if (!is_legal(op)) return;
    e = '0;
    e.aluop = alu_of(op);
    e.asrc  = !brn && (op != 6'd0);
    e.rdst  = (op == 6'd0);
    e.m2r   = lw;
    if (brn) begin
      e.state = 3'd5; e.pc_w = 1'b1; e.br = (op == 6'd4); e.bne = (op == 6'd5);
      step("br", e);
      exp_ret++;
    end else begin
      e.state = 3'd2;
      step("exec", e);
      if (lw || sw) begin
        e.state = 3'd3; e.mrd = lw; e.mwr = sw;
        mem_ready_i = 1'b0;
        for (int i = 0; i < mwait; i++) step("mem_wait", e);
        mem_ready_i = 1'b1;
        step("mem", e);
        mem_ready_i = 1'($urandom);
        e.mrd = 1'b0; e.mwr = 1'b0;
      end
      if (sw) exp_ret++;
      else begin
        e.state = 3'd4; e.rw = 1'b1;
        step("wb", e);
        exp_ret++;
      end
    end
    lat = (brn ? 3 : lw ? 5 : 4) + fwait + ((lw || sw) ? mwait : 0);
    chk("latency", 32'(busy), 32'(lat));
  endtask

  initial begin
    ctl_t e;
    logic [5:0] op;
    enable_i = 1'b1;
    mem_ready_i = 1'b1;
    #1 rst_i = 1'b1;
    #2;
    chk("reset_ctl", 32'(sample()), 32'd0);
    chk("reset_ret", 32'(retired_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("reset_hold", 32'(sample()), 32'd0);
    rst_i = 1'b0;

    run_instr(6'd0, 0, 0, 0);
    chk("r_retired", 32'(retired_o), 32'd1);
    run_instr(6'd35, 0, 0, 3);
    chk("lw_retired", 32'(retired_o), 32'd2);
    run_instr(6'd5, 0, 0, 0);
    run_instr(6'd63, 0, 0, 0);
    chk("illegal_noret", 32'(retired_o), 32'd3);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 10);
      op = (k < 9) ? ops[k] : 6'($urandom);
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Preload the counter near its top instead of retiring 65535 stores.
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFE;
    run_instr(6'd43, 0, 0, 0);
    run_instr(6'd43, 0, 0, 1);
    chk("wrap", 32'(retired_o), 32'd0);
    run_instr(6'd0, 0, 0, 0);

    enable_i = 1'b1;
    mem_ready_i = 1'b1;
    e = '0; e.mrd = 1'b1; e.ir_w = 1'b1; e.pc_w = 1'b1;
    step("fetch", e);
    instr_op_i = 6'd43;
    e = '0; e.state = 3'd1;
    step("decode", e);
    e = '0; e.state = 3'd2; e.asrc = 1'b1;
    step("exec", e);
    mem_ready_i = 1'b0;
    e.state = 3'd3; e.mwr = 1'b1;
    step("mem_wait", e);
    #1;
    chk("pre_rst_mwr", 32'(mem_write_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_mwr", 32'(mem_write_o), 32'd0);
    chk("rst_mrd", 32'(mem_read_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ret", 32'(retired_o), 32'd0);
    exp_ret = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run_instr(6'd8, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
